// File: rtl/delay_timer_bank.sv
// delay_timer_bank
//   Bank of CHANNELS independent programmable delay timers. Each channel runs
//   either as a free-running periodic pulse generator (mode 0) or as a
//   start-triggered one-shot (mode 1). Period, mode and enable are written
//   through one shared config port into per-channel shadow registers. The
//   active period is only refreshed at a reload or a start, so a period
//   change never cuts short or overruns the period currently being counted.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous, active-high reset (overrides every other input)
//   cfg_we      config write strobe
//   cfg_ch      target channel of the config write (out-of-range ignored)
//   cfg_period  new shadow period
//   cfg_mode    new shadow mode: 0 = periodic, 1 = one-shot
//   cfg_en      new channel enable
//   start       per-channel one-shot trigger
//   sig         per-channel terminal-count pulse
//   flg         per-channel "counting, terminal count not yet reached"
//   err         per-channel overrun indicator (count beyond active period)
//   any_sig     OR of all sig bits
module delay_timer_bank #(
    parameter int CHANNELS       = 4,
    parameter int CBITS          = 16,
    parameter int DEFAULT_PERIOD = 15000,
    localparam int CHW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [CBITS-1:0]    cfg_period,
    input  logic                cfg_mode,
    input  logic                cfg_en,
    input  logic [CHANNELS-1:0] start,
    output logic [CHANNELS-1:0] sig,
    output logic [CHANNELS-1:0] flg,
    output logic [CHANNELS-1:0] err,
    output logic                any_sig
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CBITS-1:0] PERIOD_RST = CBITS'(DEFAULT_PERIOD);

    // Registered per-channel state
    state_t              state_q  [CHANNELS];
    logic [CBITS-1:0]    cnt_q    [CHANNELS];
    logic [CBITS-1:0]    p_q      [CHANNELS];  // active period
    logic [CBITS-1:0]    s_q      [CHANNELS];  // shadow period
    logic [CHANNELS-1:0] m_q;                  // shadow mode
    logic [CHANNELS-1:0] ma_q;                 // active mode
    logic [CHANNELS-1:0] en_q;

    // Next-state values
    state_t              state_nx [CHANNELS];
    logic [CBITS-1:0]    cnt_nx   [CHANNELS];
    logic [CBITS-1:0]    p_nx     [CHANNELS];
    logic [CBITS-1:0]    s_nx     [CHANNELS];
    logic [CHANNELS-1:0] m_nx;
    logic [CHANNELS-1:0] ma_nx;
    logic [CHANNELS-1:0] en_nx;

    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] dis_wr;

    // Config decode. An out-of-range cfg_ch simply matches no channel.
    always_comb begin
        wr_hit = '0;
        dis_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == CHW'(i));
            dis_wr[i] = wr_hit[i] && !cfg_en;
        end
    end

    // Next-state logic for every channel
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_nx[i] = state_q[i];
            cnt_nx[i]   = cnt_q[i];
            p_nx[i]     = p_q[i];
            s_nx[i]     = s_q[i];
            m_nx[i]     = m_q[i];
            ma_nx[i]    = ma_q[i];
            en_nx[i]    = en_q[i];

            if (wr_hit[i]) begin
                s_nx[i]  = cfg_period;
                m_nx[i]  = cfg_mode;
                en_nx[i] = cfg_en;
            end

            case (state_q[i])
                IDLE: begin
                    cnt_nx[i] = '0;
                    if (en_q[i] && !m_q[i]) begin
                        state_nx[i] = COUNT;
                        p_nx[i]     = s_q[i];
                        ma_nx[i]    = 1'b0;
                    end else if (en_q[i] && m_q[i] && start[i] && !dis_wr[i]) begin
                        // A disable written in the same cycle as start wins.
                        state_nx[i] = COUNT;
                        p_nx[i]     = s_q[i];
                        ma_nx[i]    = 1'b1;
                    end
                end
                COUNT: begin
                    if (!en_q[i]) begin
                        state_nx[i] = IDLE;
                        cnt_nx[i]   = '0;
                    end else if (cnt_q[i] < p_q[i]) begin
                        cnt_nx[i] = cnt_q[i] + CBITS'(1);
                    end else if (!ma_q[i]) begin
                        // Terminal count in periodic mode: pick up the shadow period.
                        cnt_nx[i] = '0;
                        p_nx[i]   = s_q[i];
                    end else begin
                        state_nx[i] = IDLE;
                        cnt_nx[i]   = '0;
                    end
                end
                default: begin
                    state_nx[i] = IDLE;
                    cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                p_q[i]     <= PERIOD_RST;
                s_q[i]     <= PERIOD_RST;
                m_q[i]     <= 1'b0;
                ma_q[i]    <= 1'b0;
                en_q[i]    <= 1'b0;
            end else begin
                state_q[i] <= state_nx[i];
                cnt_q[i]   <= cnt_nx[i];
                p_q[i]     <= p_nx[i];
                s_q[i]     <= s_nx[i];
                m_q[i]     <= m_nx[i];
                ma_q[i]    <= ma_nx[i];
                en_q[i]    <= en_nx[i];
            end
        end
    end

    // Outputs decoded straight from registered state
    always_comb begin
        sig = '0;
        flg = '0;
        err = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sig[i] = (state_q[i] == COUNT) && (cnt_q[i] == p_q[i]);
            flg[i] = (state_q[i] == COUNT) && (cnt_q[i] <  p_q[i]);
            err[i] = (state_q[i] == COUNT) && (cnt_q[i] >  p_q[i]);
        end
        any_sig = |sig;
    end

endmodule
